zmenu_cursor_ctrl: RTL and testbench
====================================

// Module: zmenu_cursor_ctrl
// PURPOSE
//  Menu cursor controller for the TFT43 UI. Turns debounced push-button events into a wrapped cursor index and a committed SIN period count.
//  Schedules the shared LCD item-draw engine over a req/ack handshake: un-highlight the old item, highlight the new one, full menu repaint on enable.
//  Sits between ZPush_Button (debounce) and the LCD menu renderer.
// PARAMETERS
//  MAX_CURSOR_INDEX   10      last valid cursor index; cursor range 0..MAX_CURSOR_INDEX
//  REPEAT_DELAY       24'd5_000_000  hold cycles before auto-repeat starts (ZMENU_AUTOREPEAT_EN only)
//  REPEAT_RATE        24'd1_000_000  cycles between repeated steps (ZMENU_AUTOREPEAT_EN only)
// PORTS
//  clk                  in   1  system clock; single clock domain
//  rst_n                in   1  reset, synchronous, active-low
//  en                   in   1  block enable; low = hold outputs in reset values
//  iBtn_Pulse           in   4  1-cycle debounced presses: [0]Prev [1]Next [2]Okay [3]Cancel
//  iBtn_Level           in   4  debounced held levels, same bit order (auto-repeat source)
//  oCursor_Index        out  4  logical cursor position
//  oActive_Periods_Num  out  3  committed period count code 0..4 (Period1..Period5)
//  oDraw_Req            out  1  draw request to LCD item engine
//  oDraw_Item           out  4  item index to draw; stable while oDraw_Req=1
//  oDraw_Hilite         out  1  1 = draw highlighted, 0 = normal; stable while oDraw_Req=1
//  iDraw_Ack            in   1  engine accepted/finished the item; sampled only while oDraw_Req=1
//  oBusy                out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge) and en=0: all outputs 0, FSM=IDLE, drawn_idx=0, repeat counters=0. en=0 drops oDraw_Req mid-handshake. The engine tolerates an aborted request.
//  Cursor update (en=1): one event per cycle, priority Prev>Next>Okay>Cancel.
//   Prev: idx>=1 ? idx-1 : MAX_CURSOR_INDEX.  Next: idx<=MAX-1 ? idx+1 : 0.
//   Okay on ZCURSOR_INDEX_PERIODn (n=1..5): oActive_Periods_Num<=n-1 next cycle. Okay elsewhere: no effect.
//   Cancel: oCursor_Index<=0. oActive_Periods_Num unchanged.
//  The cursor updates the cycle after the event, regardless of FSM state. Drawing lags and coalesces.
//  FSM states: IDLE, FULL, GAP, DRAW_OLD, DRAW_NEW.
//   IDLE: if en rose last cycle -> FULL (item_cnt=0); else if oCursor_Index!=drawn_idx -> DRAW_OLD.
//   FULL: req item_cnt, hilite=(item_cnt==oCursor_Index). On ack: item_cnt++. After item MAX_CURSOR_INDEX: drawn_idx<=the hilited index -> GAP -> IDLE.
//   DRAW_OLD: req drawn_idx, hilite=0. On ack: latch target<=oCursor_Index -> GAP -> DRAW_NEW.
//   DRAW_NEW: req target, hilite=1. On ack: drawn_idx<=target -> GAP -> IDLE. IDLE re-checks, so moves made during a draw are coalesced.
//  Handshake: a transfer completes on a posedge with oDraw_Req&&iDraw_Ack. oDraw_Req is low for exactly one cycle (GAP) between transfers.
//   Ack with req=0 is ignored. Minimum transfer 1 cycle (ack already high).
//  Widths: 4-bit index and counter compares. MAX_CURSOR_INDEX<=15 enforced by a generate-time check.
// CONFIGURATION
//  ZMENU_AUTOREPEAT_EN defined: Prev/Next level held for REPEAT_DELAY cycles produces one extra step, then one step every REPEAT_RATE cycles until release.
//   Both levels high: no repeat. A pulse or release resets the counter. Repeat steps use the same priority slot as the pulse.
//  Undefined: iBtn_Level is ignored, there are no repeat counters, and only iBtn_Pulse moves the cursor.
// STRUCTURE
//  zmenu_pkg (shared include): ZCURSOR_INDEX_PERIOD1..5 = 4'd1..4'd5, button bit positions BTN_PREV/NEXT/OKAY/CANCEL, FSM state encodings.
//  Sub-module zmenu_key_repeat: one instance per Prev/Next, present only under ZMENU_AUTOREPEAT_EN. Controller FSM and cursor logic stay in this module.
// TESTING
//  1 en 0->1, ack tied high -> 11 requests items 0..10, only item 0 hilite=1, each req separated by one low cycle, oBusy falls after.
//  2 cursor=0, Prev pulse -> oCursor_Index=10. Next pulse at 10 -> 0. Draw pairs (0,n)->(10,h) and (10,n)->(0,h).
//  3 ack held low, 3 Next pulses during DRAW_OLD -> one DRAW_NEW of item 3 only. Then IDLE with drawn_idx=3.
//  4 cursor=3 (Period3), Okay -> oActive_Periods_Num=2. Okay at cursor 7 -> stays 2. Cancel -> cursor 0, periods still 2.
//  5 Prev+Next same cycle -> cursor-1 only. en low during req -> req=0, outputs 0 next cycle. rst_n low mid-FULL -> IDLE, all outputs 0.
//  6 ZMENU_AUTOREPEAT_EN, DELAY=8, RATE=4, Next held 20 cycles -> steps at press, +8, +12, +16, +20. Without the macro -> 1 step.

Source files
------------

// File: rtl/zmenu_pkg.sv
// Shared constants and types for the menu cursor controller.
// Period item indices, button bit positions, FSM state encodings.
package zmenu_pkg;

  localparam logic [3:0] ZCURSOR_INDEX_PERIOD1 = 4'd1;
  localparam logic [3:0] ZCURSOR_INDEX_PERIOD2 = 4'd2;
  localparam logic [3:0] ZCURSOR_INDEX_PERIOD3 = 4'd3;
  localparam logic [3:0] ZCURSOR_INDEX_PERIOD4 = 4'd4;
  localparam logic [3:0] ZCURSOR_INDEX_PERIOD5 = 4'd5;

  localparam int BTN_PREV   = 0;
  localparam int BTN_NEXT   = 1;
  localparam int BTN_OKAY   = 2;
  localparam int BTN_CANCEL = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FULL     = 3'd1,
    ST_GAP      = 3'd2,
    ST_DRAW_OLD = 3'd3,
    ST_DRAW_NEW = 3'd4
  } zmenu_state_e;

  function automatic logic is_period(
    input logic [3:0] idx
  );
    return (idx >= ZCURSOR_INDEX_PERIOD1) &&
           (idx <= ZCURSOR_INDEX_PERIOD5);
  endfunction

endpackage

// File: rtl/zmenu_cursor_ctrl_if.sv
// Item-draw handshake between cursor controller and LCD item engine.
// master: drives oDraw_Req/oDraw_Item/oDraw_Hilite, samples iDraw_Ack.
interface zmenu_cursor_ctrl_if;

  logic       oDraw_Req;
  logic [3:0] oDraw_Item;
  logic       oDraw_Hilite;
  logic       iDraw_Ack;

  modport master (
    output oDraw_Req,
    output oDraw_Item,
    output oDraw_Hilite,
    input  iDraw_Ack
  );

  modport slave (
    input  oDraw_Req,
    input  oDraw_Item,
    input  oDraw_Hilite,
    output iDraw_Ack
  );

endinterface

// File: rtl/zmenu_key_repeat.sv
// Auto-repeat generator for one held button (used under ZMENU_AUTOREPEAT_EN).
// Ports: clk, rst_n, en, level, pulse, block in; step out (1-cycle strobe).
module zmenu_key_repeat #(
  parameter logic [23:0] DELAY = 24'd5_000_000,
  parameter logic [23:0] RATE  = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic level,
  input  logic pulse,
  input  logic block,
  output logic step
);

  logic [23:0] cnt;
  logic        armed;
  logic        hold;

  // A pulse restarts the hold timer; the press itself is the first step.
  assign hold = en & level & ~pulse & ~block;

  assign step = hold &
    (armed ? (cnt == RATE - 24'd1)
           : (cnt == DELAY - 24'd1));

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (!hold) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (step) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      cnt   <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/zmenu_cursor_ctrl.sv
// Menu cursor controller: button events -> wrapped cursor, period code,
// and item-draw scheduling over the draw handshake (draw: master modport).
// Ports: clk, rst_n, en, iBtn_Pulse[3:0], iBtn_Level[3:0] in;
// oCursor_Index[3:0], oActive_Periods_Num[2:0], oBusy out.
// Optional: ZMENU_AUTOREPEAT_EN enables Prev/Next auto-repeat.
module zmenu_cursor_ctrl
  import zmenu_pkg::*;
#(
  parameter int          MAX_CURSOR_INDEX = 10,
  parameter logic [23:0] REPEAT_DELAY     = 24'd5_000_000,
  parameter logic [23:0] REPEAT_RATE      = 24'd1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [3:0]                 iBtn_Pulse,
  input  logic [3:0]                 iBtn_Level,
  output logic [3:0]                 oCursor_Index,
  output logic [2:0]                 oActive_Periods_Num,
  output logic                       oBusy,
  zmenu_cursor_ctrl_if.master        draw
);

  localparam logic [3:0] MAX_IDX = 4'(MAX_CURSOR_INDEX);

  if (MAX_CURSOR_INDEX > 15 || MAX_CURSOR_INDEX < 1) begin : g_bad_max
    $error("MAX_CURSOR_INDEX must be 1..15");
  end

  logic ev_prev;
  logic ev_next;

`ifdef ZMENU_AUTOREPEAT_EN
  logic rep_prev;
  logic rep_next;
  logic both_held;

  assign both_held = iBtn_Level[BTN_PREV] & iBtn_Level[BTN_NEXT];

  zmenu_key_repeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_rep_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .level (iBtn_Level[BTN_PREV]),
    .pulse (iBtn_Pulse[BTN_PREV]),
    .block (both_held),
    .step  (rep_prev)
  );

  zmenu_key_repeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_rep_next (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .level (iBtn_Level[BTN_NEXT]),
    .pulse (iBtn_Pulse[BTN_NEXT]),
    .block (both_held),
    .step  (rep_next)
  );

  assign ev_prev = iBtn_Pulse[BTN_PREV] | rep_prev;
  assign ev_next = iBtn_Pulse[BTN_NEXT] | rep_next;
`else
  logic unused_cfg;

  assign unused_cfg = ^{iBtn_Level, REPEAT_DELAY, REPEAT_RATE};
  assign ev_prev    = iBtn_Pulse[BTN_PREV];
  assign ev_next    = iBtn_Pulse[BTN_NEXT];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      oCursor_Index       <= '0;
      oActive_Periods_Num <= '0;
    end else begin
      priority case (1'b1)
        ev_prev: begin
          oCursor_Index <= (oCursor_Index >= 4'd1) ?
            oCursor_Index - 4'd1 : MAX_IDX;
        end
        ev_next: begin
          oCursor_Index <= (oCursor_Index < MAX_IDX) ?
            oCursor_Index + 4'd1 : 4'd0;
        end
        iBtn_Pulse[BTN_OKAY]: begin
          if (is_period(oCursor_Index))
            oActive_Periods_Num <= 3'(oCursor_Index - 4'd1);
        end
        iBtn_Pulse[BTN_CANCEL]: begin
          oCursor_Index <= '0;
        end
        default: ;
      endcase
    end
  end

  zmenu_state_e state;
  zmenu_state_e ret_state;
  logic         en_q;
  logic [3:0]   item_cnt;
  logic [3:0]   drawn_idx;
  logic [3:0]   target;
  logic [3:0]   hilite_idx;
  logic         req_q;
  logic [3:0]   item_q;
  logic         hil_q;
  logic         xfer;

  assign draw.oDraw_Req    = req_q;
  assign draw.oDraw_Item   = item_q;
  assign draw.oDraw_Hilite = hil_q;
  assign xfer              = req_q & draw.iDraw_Ack;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state      <= ST_IDLE;
      ret_state  <= ST_IDLE;
      en_q       <= 1'b0;
      item_cnt   <= '0;
      drawn_idx  <= '0;
      target     <= '0;
      hilite_idx <= '0;
      req_q      <= 1'b0;
      item_q     <= '0;
      hil_q      <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      en_q <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (!en_q) begin
            state      <= ST_FULL;
            item_cnt   <= '0;
            hilite_idx <= oCursor_Index;
            req_q      <= 1'b1;
            item_q     <= '0;
            hil_q      <= (oCursor_Index == 4'd0);
            oBusy      <= 1'b1;
          end else if (oCursor_Index != drawn_idx) begin
            state  <= ST_DRAW_OLD;
            req_q  <= 1'b1;
            item_q <= drawn_idx;
            hil_q  <= 1'b0;
            oBusy  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            req_q <= 1'b0;
            state <= ST_GAP;
            if (hil_q)
              hilite_idx <= item_q;
            if (item_cnt == MAX_IDX) begin
              // Cursor may have moved mid-repaint; IDLE fixes it up.
              drawn_idx <= hil_q ? item_q : hilite_idx;
              ret_state <= ST_IDLE;
            end else begin
              item_cnt  <= item_cnt + 4'd1;
              ret_state <= ST_FULL;
            end
          end
        end
        ST_DRAW_OLD: begin
          if (xfer) begin
            req_q     <= 1'b0;
            target    <= oCursor_Index;
            ret_state <= ST_DRAW_NEW;
            state     <= ST_GAP;
          end
        end
        ST_DRAW_NEW: begin
          if (xfer) begin
            req_q     <= 1'b0;
            drawn_idx <= target;
            ret_state <= ST_IDLE;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ret_state;
          if (ret_state == ST_FULL) begin
            req_q  <= 1'b1;
            item_q <= item_cnt;
            hil_q  <= (item_cnt == oCursor_Index);
          end else if (ret_state == ST_DRAW_NEW) begin
            req_q  <= 1'b1;
            item_q <= target;
            hil_q  <= 1'b1;
          end else begin
            oBusy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zmenu_cursor_ctrl.sv
// Self-checking bench for zmenu_cursor_ctrl: scenario tasks plus a
// randomized run against a cursor/screen model of the menu.
module tb_zmenu_cursor_ctrl;

  localparam int MAXI  = 10;
  localparam int DELAY = 8;
  localparam int RATE  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] pulse;
  logic [3:0] level;
  logic [3:0] cur;
  logic [2:0] per;
  logic       busy;

  zmenu_cursor_ctrl_if ifc ();

  zmenu_cursor_ctrl #(
    .MAX_CURSOR_INDEX (MAXI),
    .REPEAT_DELAY     (24'(DELAY)),
    .REPEAT_RATE      (24'(RATE))
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .iBtn_Pulse          (pulse),
    .iBtn_Level          (level),
    .oCursor_Index       (cur),
    .oActive_Periods_Num (per),
    .oBusy               (busy),
    .draw                (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_cur  = 0;
  int m_per  = 0;

  // Engine-side log: what the LCD would have drawn.
  int   xf_item[$];
  int   xf_hil[$];
  int   xf_cyc[$];
  int   ncyc = 0;
  int   viol = 0;
  logic [15:0] scr = '0;
  logic pr_req = 1'b0;
  logic pr_ack = 1'b0;
  logic [3:0] pr_item = '0;
  logic pr_hil = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_n && en) begin
      if (pr_req && !pr_ack && ifc.oDraw_Req &&
          (ifc.oDraw_Item != pr_item ||
           ifc.oDraw_Hilite != pr_hil))
        viol++;
      if (pr_req && !pr_ack && !ifc.oDraw_Req)
        viol++;
      if (ifc.oDraw_Req && ifc.iDraw_Ack) begin
        xf_item.push_back(int'(ifc.oDraw_Item));
        xf_hil.push_back(int'(ifc.oDraw_Hilite));
        xf_cyc.push_back(ncyc);
        scr[ifc.oDraw_Item] = ifc.oDraw_Hilite;
      end
    end
    pr_req  = ifc.oDraw_Req && rst_n && en;
    pr_ack  = ifc.iDraw_Ack;
    pr_item = ifc.oDraw_Item;
    pr_hil  = ifc.oDraw_Hilite;
  end

  task automatic m_update();
    if (!rst_n || !en) begin
      m_cur = 0;
      m_per = 0;
    end else if (pulse[0]) begin
      m_cur = (m_cur == 0) ? MAXI : m_cur - 1;
    end else if (pulse[1]) begin
      m_cur = (m_cur == MAXI) ? 0 : m_cur + 1;
    end else if (pulse[2]) begin
      if (m_cur >= 1 && m_cur <= 5)
        m_per = m_cur - 1;
    end else if (pulse[3]) begin
      m_cur = 0;
    end
  endtask

  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    xf_item.delete();
    xf_hil.delete();
    xf_cyc.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    tick();
    tick();
    tick();
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%0b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    pulse = 4'b0010;
    tick();
    tick();
    pulse = 4'b0000;
    tick();
    checks += 6;
    if (cur !== 4'd0) begin
      errors++; $display("FAIL rst_cur got %0d want 0", cur);
    end
    if (per !== 3'd0) begin
      errors++; $display("FAIL rst_per got %0d want 0", per);
    end
    if (ifc.oDraw_Req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %0b want 0", ifc.oDraw_Req);
    end
    if (ifc.oDraw_Item !== 4'd0) begin
      errors++; $display("FAIL rst_item got %0d want 0", ifc.oDraw_Item);
    end
    if (ifc.oDraw_Hilite !== 1'b0) begin
      errors++; $display("FAIL rst_hil got %0b want 0", ifc.oDraw_Hilite);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %0b want 0", busy);
    end
  endtask

  task automatic test_full_repaint();
    rst_n = 1'b1;
    en    = 1'b0;
    ifc.iDraw_Ack = 1'b1;
    tick();
    clear_log();
    en = 1'b1;
    wait_idle("full");
    checks++;
    if (xf_item.size() != MAXI + 1) begin
      errors++;
      $display("FAIL full_count got %0d want %0d",
               xf_item.size(), MAXI + 1);
    end else begin
      for (int i = 0; i <= MAXI; i++) begin
        checks += 2;
        if (xf_item[i] != i || xf_hil[i] != int'(i == 0)) begin
          errors++;
          $display("FAIL full_item%0d got %0d/%0d want %0d/%0d",
                   i, xf_item[i], xf_hil[i], i, int'(i == 0));
        end
        if (i > 0 && xf_cyc[i] - xf_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL full_gap%0d got %0d want 2",
                   i, xf_cyc[i] - xf_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    clear_log();
    pulse = 4'b0001;
    tick();
    pulse = 4'b0000;
    checks++;
    if (cur !== 4'(MAXI)) begin
      errors++; $display("FAIL wrap_prev got %0d want %0d", cur, MAXI);
    end
    wait_idle("wrap_prev");
    pulse = 4'b0010;
    tick();
    pulse = 4'b0000;
    checks++;
    if (cur !== 4'd0) begin
      errors++; $display("FAIL wrap_next got %0d want 0", cur);
    end
    wait_idle("wrap_next");
    checks++;
    if (xf_item.size() != 4 ||
        xf_item[0] != 0 || xf_hil[0] != 0 ||
        xf_item[1] != MAXI || xf_hil[1] != 1 ||
        xf_item[2] != MAXI || xf_hil[2] != 0 ||
        xf_item[3] != 0 || xf_hil[3] != 1) begin
      errors++;
      $display("FAIL wrap_draws got n=%0d want (0,0)(10,1)(10,0)(0,1)",
               xf_item.size());
    end
  endtask

  task automatic test_coalesce();
    clear_log();
    ifc.iDraw_Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse = 4'b0010;
      tick();
    end
    pulse = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    checks += 3;
    if (cur !== 4'd3) begin
      errors++; $display("FAIL coal_cur got %0d want 3", cur);
    end
    if (ifc.oDraw_Req !== 1'b1 || ifc.oDraw_Item !== 4'd0 ||
        ifc.oDraw_Hilite !== 1'b0) begin
      errors++;
      $display("FAIL coal_old got %0b/%0d/%0b want 1/0/0",
               ifc.oDraw_Req, ifc.oDraw_Item, ifc.oDraw_Hilite);
    end
    if (xf_item.size() != 0) begin
      errors++; $display("FAIL coal_noack got %0d want 0", xf_item.size());
    end
    ifc.iDraw_Ack = 1'b1;
    wait_idle("coal");
    checks += 2;
    if (xf_item.size() != 2 || xf_item[0] != 0 || xf_hil[0] != 0 ||
        xf_item[1] != 3 || xf_hil[1] != 1) begin
      errors++;
      $display("FAIL coal_draws got n=%0d want (0,0)(3,1)", xf_item.size());
    end
    if (scr[10:0] !== 11'(1 << 3)) begin
      errors++; $display("FAIL coal_screen got %b want one-hot 3", scr[10:0]);
    end
  endtask

  task automatic test_periods();
    pulse = 4'b0100;
    tick();
    pulse = 4'b0000;
    checks++;
    if (per !== 3'd2) begin
      errors++; $display("FAIL per_p3 got %0d want 2", per);
    end
    for (int i = 0; i < 4; i++) begin
      pulse = 4'b0010;
      tick();
    end
    pulse = 4'b0100;
    tick();
    pulse = 4'b0000;
    checks += 2;
    if (cur !== 4'd7) begin
      errors++; $display("FAIL per_cur7 got %0d want 7", cur);
    end
    if (per !== 3'd2) begin
      errors++; $display("FAIL per_okay7 got %0d want 2", per);
    end
    pulse = 4'b1000;
    tick();
    pulse = 4'b0000;
    checks += 2;
    if (cur !== 4'd0) begin
      errors++; $display("FAIL cancel_cur got %0d want 0", cur);
    end
    if (per !== 3'd2) begin
      errors++; $display("FAIL cancel_per got %0d want 2", per);
    end
    wait_idle("per");
  endtask

  task automatic test_edges();
    int n;
    pulse = 4'b0011;
    tick();
    pulse = 4'b0000;
    checks++;
    if (cur !== 4'(MAXI)) begin
      errors++; $display("FAIL both_cur got %0d want %0d", cur, MAXI);
    end
    wait_idle("both");
    ifc.iDraw_Ack = 1'b0;
    pulse = 4'b0010;
    tick();
    pulse = 4'b0000;
    n = 0;
    while (!ifc.oDraw_Req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.oDraw_Req !== 1'b1) begin
      errors++; $display("FAIL abort_req_rise got 0 want 1");
    end
    en = 1'b0;
    tick();
    checks += 3;
    if (ifc.oDraw_Req !== 1'b0) begin
      errors++; $display("FAIL abort_req got %0b want 0", ifc.oDraw_Req);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy got %0b want 0", busy);
    end
    if (cur !== 4'd0 || per !== 3'd0) begin
      errors++; $display("FAIL abort_out got %0d/%0d want 0/0", cur, per);
    end
    ifc.iDraw_Ack = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midfull_busy got %0b want 1", busy);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ifc.oDraw_Req !== 1'b0 ||
        ifc.oDraw_Item !== 4'd0 || ifc.oDraw_Hilite !== 1'b0 ||
        cur !== 4'd0 || per !== 3'd0) begin
      errors++;
      $display("FAIL midfull_rst got busy=%0b req=%0b item=%0d want 0",
               busy, ifc.oDraw_Req, ifc.oDraw_Item);
    end
    rst_n = 1'b1;
    wait_idle("rst_full");
    checks++;
    if (scr[10:0] !== 11'd1) begin
      errors++; $display("FAIL rst_screen got %b want one-hot 0", scr[10:0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pulse = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      ifc.iDraw_Ack = 1'($urandom_range(0, 1));
      tick();
      checks += 2;
      if (cur !== 4'(m_cur)) begin
        errors++; $display("FAIL rnd_cur@%0d got %0d want %0d", i, cur, m_cur);
      end
      if (per !== 3'(m_per)) begin
        errors++; $display("FAIL rnd_per@%0d got %0d want %0d", i, per, m_per);
      end
    end
    pulse = 4'b0000;
    ifc.iDraw_Ack = 1'b1;
    wait_idle("rnd");
    checks += 2;
    if (scr[10:0] !== 11'(1 << m_cur)) begin
      errors++;
      $display("FAIL rnd_screen got %b want one-hot %0d", scr[10:0], m_cur);
    end
    if (viol != 0) begin
      errors++; $display("FAIL handshake_viol got %0d want 0", viol);
    end
  endtask

  task automatic test_autorepeat();
    int exp_t[$];
    int got_t[$];
    int t;
    int prev;
    int hold_last;
    hold_last = 20;
    pulse = 4'b1000;
    tick();
    pulse = 4'b0000;
    wait_idle("rep_pre");
    exp_t.push_back(0);
`ifdef ZMENU_AUTOREPEAT_EN
    t = DELAY;
    while (t <= hold_last) begin
      exp_t.push_back(t);
      t += RATE;
    end
`endif
    prev = int'(cur);
    for (int i = 0; i < hold_last + 6; i++) begin
      pulse = (i == 0) ? 4'b0010 : 4'b0000;
      level = (i <= hold_last) ? 4'b0010 : 4'b0000;
      tick();
      if (int'(cur) != prev) got_t.push_back(i);
      prev = int'(cur);
    end
    pulse = 4'b0000;
    level = 4'b0000;
    m_cur = exp_t.size();
    checks += 2;
    if (got_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL rep_steps got %0d want %0d", got_t.size(), exp_t.size());
    end else begin
      for (int i = 0; i < exp_t.size(); i++) begin
        checks++;
        if (got_t[i] != exp_t[i]) begin
          errors++;
          $display("FAIL rep_t%0d got %0d want %0d", i, got_t[i], exp_t[i]);
        end
      end
    end
    if (cur !== 4'(m_cur)) begin
      errors++; $display("FAIL rep_cur got %0d want %0d", cur, m_cur);
    end
    wait_idle("rep");
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    pulse = 4'b0000;
    level = 4'b0000;
    ifc.iDraw_Ack = 1'b0;
    test_reset();
    test_full_repaint();
    test_wrap();
    test_coalesce();
    test_periods();
    test_edges();
    test_random();
    test_autorepeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
